// File: rtl/breath_pkg.sv
// Shared types and defaults for the breathing-LED sequencer.
package breath_pkg;

   typedef enum logic [1:0] {
      PH_RISE    = 2'd0,
      PH_HOLD_HI = 2'd1,
      PH_FALL    = 2'd2,
      PH_HOLD_LO = 2'd3
   } phase_t;

   localparam int unsigned DUTY_W_DEF     = 4;
   localparam int unsigned SPEED_W_DEF    = 4;
   localparam int unsigned SPEED_INIT_DEF = 4;
   localparam int unsigned HOLD_STEPS_DEF = 2;

   // All-ones value of a w-bit field.
   function automatic int unsigned max_val(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one debounced key level.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic level_q;

   // Remember the previous level to spot low-to-high transitions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= 1'b0;
      else     level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/breath_ctrl.sv
// Breathing-LED sequencer: key-driven speed, paced rise/hold/fall/hold
// duty envelope, duty updates presented only at PWM frame boundaries.
module breath_ctrl
   import breath_pkg::*;
#(
   parameter int unsigned DUTY_W     = DUTY_W_DEF,
   parameter int unsigned SPEED_W    = SPEED_W_DEF,
   parameter int unsigned SPEED_INIT = SPEED_INIT_DEF,
   parameter int unsigned HOLD_STEPS = HOLD_STEPS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_up,
   input  logic               key_down,
   output logic [DUTY_W-1:0]  duty,
   output logic               load,
   output logic [SPEED_W-1:0] speed,
   output logic [1:0]         phase
);

   localparam logic [DUTY_W-1:0]  DUTY_MAX  = DUTY_W'(max_val(DUTY_W));
   localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(max_val(SPEED_W));
   localparam logic [SPEED_W-1:0] SPEED_MIN = SPEED_W'(1);
   localparam int unsigned        HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

   logic [DUTY_W-1:0]  frm_cnt;
   logic [SPEED_W-1:0] pace_cnt;
   logic [SPEED_W-1:0] thr;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic [DUTY_W-1:0]  duty_nxt;
   logic               frame_tick, step;
   logic               up_pulse, down_pulse;
   phase_t             state, state_nxt;

   key_edge u_up   (.clk(clk), .rst(rst), .level(key_up),   .pulse(up_pulse));
   key_edge u_down (.clk(clk), .rst(rst), .level(key_down), .pulse(down_pulse));

   assign frame_tick = (frm_cnt == DUTY_MAX);
   assign thr        = SPEED_MAX - speed;
   // >= rather than == so a speed increase below the current pace count never stalls
   assign step       = frame_tick && (pace_cnt >= thr);
   assign phase      = state;

   // Free-running frame counter; load marks the first cycle after each wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_cnt <= '0;
         load    <= 1'b0;
      end else begin
         frm_cnt <= frm_cnt + DUTY_W'(1);
         load    <= frame_tick;
      end
   end

   // Speed setting: single key edges move it one notch, saturating at 1 and max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         speed <= SPEED_W'(SPEED_INIT);
      else if (up_pulse && !down_pulse && speed != SPEED_MAX)
         speed <= speed + SPEED_W'(1);
      else if (down_pulse && !up_pulse && speed != SPEED_MIN)
         speed <= speed - SPEED_W'(1);
   end

   // Frame pacing: count frames until the speed-derived threshold is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pace_cnt <= '0;
      else if (frame_tick)
         pace_cnt <= step ? '0 : pace_cnt + SPEED_W'(1);
   end

   // Envelope state, duty and hold counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= PH_RISE;
         duty     <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         duty     <= duty_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Envelope next-state: advances only on a step, which always ends a frame.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      hold_nxt  = hold_cnt;
      if (step) begin
         case (state)
            PH_RISE: begin
               duty_nxt = duty + DUTY_W'(1);
               if (duty == DUTY_MAX - DUTY_W'(1)) begin
                  state_nxt = PH_HOLD_HI;
                  hold_nxt  = '0;
               end
            end
            PH_HOLD_HI: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt = PH_FALL;
                  hold_nxt  = '0;
               end else begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end
            PH_FALL: begin
               duty_nxt = duty - DUTY_W'(1);
               if (duty == DUTY_W'(1)) begin
                  state_nxt = PH_HOLD_LO;
                  hold_nxt  = '0;
               end
            end
            PH_HOLD_LO: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt = PH_RISE;
                  hold_nxt  = '0;
               end else begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_breath_ctrl.sv
// Self-checking bench for breath_ctrl against an envelope-position model.
module tb_breath_ctrl;

   localparam int DW     = 4;
   localparam int SW     = 4;
   localparam int SI     = 4;
   localparam int HS     = 2;
   localparam int DMAX   = (1 << DW) - 1;
   localparam int SMAX   = (1 << SW) - 1;
   localparam int FRAME  = 1 << DW;
   localparam int PERIOD = 2 * DMAX + 2 * HS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_up = 1'b0;
   logic          key_down = 1'b0;
   logic [DW-1:0] duty;
   logic          load;
   logic [SW-1:0] speed;
   logic [1:0]    phase;

   int checks = 0;
   int errors = 0;

   breath_ctrl #(.DUTY_W(DW), .SPEED_W(SW), .SPEED_INIT(SI), .HOLD_STEPS(HS)) dut (
      .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down),
      .duty(duty), .load(load), .speed(speed), .phase(phase)
   );

   always #5 clk = ~clk;

   // Envelope as a function of steps taken (mod PERIOD).
   function automatic int env_duty(input int p);
      if (p < DMAX)               return p;
      else if (p < DMAX + HS)     return DMAX;
      else if (p < 2*DMAX + HS)   return 2*DMAX + HS - p;
      else                        return 0;
   endfunction

   function automatic int env_phase(input int p);
      if (p < DMAX)               return 0;
      else if (p < DMAX + HS)     return 1;
      else if (p < 2*DMAX + HS)   return 2;
      else                        return 3;
   endfunction

   // Reference model: cycle count, speed, frames since step, envelope position.
   int   m_cyc, m_speed, m_pace, m_pos;
   logic m_load, m_up, m_dn;
   logic m_ue, m_de, m_fend;
   assign m_ue   = key_up & ~m_up;
   assign m_de   = key_down & ~m_dn;
   assign m_fend = (m_cyc % FRAME) == FRAME - 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc <= 0; m_load <= 1'b0; m_speed <= SI; m_pace <= 0; m_pos <= 0;
         m_up <= 1'b0; m_dn <= 1'b0;
      end else begin
         m_cyc  <= m_cyc + 1;
         m_load <= m_fend;
         m_up   <= key_up;
         m_dn   <= key_down;
         if (m_ue && !m_de)      m_speed <= (m_speed + 1 > SMAX) ? SMAX : m_speed + 1;
         else if (m_de && !m_ue) m_speed <= (m_speed - 1 < 1) ? 1 : m_speed - 1;
         if (m_fend) begin
            if (m_pace >= SMAX - m_speed) begin
               m_pace <= 0;
               m_pos  <= (m_pos + 1) % PERIOD;
            end else begin
               m_pace <= m_pace + 1;
            end
         end
      end
   end

   logic [DW+SW+2:0] dut_vec, exp_vec;
   assign dut_vec = {duty, load, speed, phase};
   assign exp_vec = {DW'(env_duty(m_pos)), m_load, SW'(m_speed), 2'(env_phase(m_pos))};

   task automatic test_reset;
      int n;
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({duty, load, speed, phase} !== {DW'(0), 1'b0, SW'(SI), 2'd0}) begin
         errors++;
         $display("FAIL reset_init got duty=%0d load=%0b speed=%0d phase=%0d exp 0/0/%0d/0", duty, load, speed, phase, SI);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk); n++;
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_reset t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end while (!load && n < 40);
      checks++;
      if (n != FRAME) begin errors++; $display("FAIL reset_first_load got %0d cycles exp %0d", n, FRAME); end
   endtask

   task automatic test_frame_timing;
      int loads = 1, since = 0, prev_duty = 0;
      for (int c = 0; c < 24 * FRAME + 32 && loads < 24; c++) begin
         @(negedge clk); since++;
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_frame t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         if (load) begin
            loads++;
            checks++;
            if (since != FRAME) begin errors++; $display("FAIL load_spacing got %0d exp %0d", since, FRAME); end
            since = 0;
            if (loads == 11 || loads == 12 || loads == 23 || loads == 24) begin
               checks++;
               if (int'(duty) != loads / 12) begin errors++; $display("FAIL duty_at_load%0d got %0d exp %0d", loads, duty, loads / 12); end
            end
         end else begin
            checks++;
            if (int'(duty) != prev_duty) begin errors++; $display("FAIL duty_midframe got %0d exp %0d", duty, prev_duty); end
         end
         prev_duty = duty;
      end
      checks++;
      if (loads != 24) begin errors++; $display("FAIL frame_timeout got %0d loads exp 24", loads); end
   endtask

   task automatic test_speed_sat;
      for (int p = 0; p < 12; p++) begin
         for (int c = 0; c < 480; c++) begin
            key_up = (c < 40);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_sat_up t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         end
         checks++;
         if (int'(speed) != ((SI + p + 1 > SMAX) ? SMAX : SI + p + 1)) begin
            errors++; $display("FAIL speed_up_pulse%0d got %0d", p, speed);
         end
      end
      for (int p = 0; p < 20; p++) begin
         for (int c = 0; c < 480; c++) begin
            key_down = (c < 40);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || speed == '0) begin errors++; $display("FAIL model_sat_dn t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         end
         checks++;
         if (int'(speed) != ((SMAX - p - 1 < 1) ? 1 : SMAX - p - 1)) begin
            errors++; $display("FAIL speed_dn_pulse%0d got %0d", p, speed);
         end
      end
   endtask

   task automatic test_simultaneous;
      for (int c = 0; c < 20; c++) begin
         key_up = (c < 10); key_down = (c < 10);
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_both t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end
      checks++;
      if (speed != SW'(1)) begin errors++; $display("FAIL both_keys got %0d exp 1", speed); end
      for (int c = 0; c < 105; c++) begin
         key_up = (c < 100);
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_held t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end
      checks++;
      if (speed != SW'(2)) begin errors++; $display("FAIL held_key got %0d exp 2", speed); end
      // random-length pulses to climb to the top
      for (int p = 0; p < 14; p++) begin
         int hi = $urandom_range(1, 5), lo = $urandom_range(1, 5);
         for (int c = 0; c < hi + lo; c++) begin
            key_up = (c < hi);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_climb t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         end
      end
      checks++;
      if (int'(speed) != SMAX) begin errors++; $display("FAIL climb_to_max got %0d exp %0d", speed, SMAX); end
   endtask

   task automatic test_envelope;
      int last_ph = -1, n = 0, since = 0, loads = 0, start = 0;
      bit found = 0;
      while (!found && n < 3000) begin
         @(negedge clk); n++;
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_env_sync t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         if (load) begin
            if (last_ph == 3 && phase == 2'd0 && duty == '0) found = 1;
            last_ph = phase;
         end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL env_start_timeout got none exp wrap within 3000"); end
      start = n;
      while (found && loads < PERIOD && n < start + PERIOD * FRAME + 64) begin
         @(negedge clk); n++; since++;
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_env t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         if (load) begin
            loads++;
            checks++;
            if (int'(duty) != env_duty(loads % PERIOD) || int'(phase) != env_phase(loads % PERIOD) || since != FRAME) begin
               errors++;
               $display("FAIL env_load%0d got duty=%0d phase=%0d gap=%0d exp duty=%0d phase=%0d gap=%0d", loads, duty, phase, since,
                        env_duty(loads % PERIOD), env_phase(loads % PERIOD), FRAME);
            end
            since = 0;
         end
      end
      checks++;
      if (n - start != PERIOD * FRAME) begin errors++; $display("FAIL env_period got %0d exp %0d", n - start, PERIOD * FRAME); end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      while (!(duty == DW'(9) && phase == 2'd2) && n < 2000) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 2000) begin errors++; $display("FAIL reset_mid_sync got timeout exp duty9 in fall"); end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({duty, load, speed, phase} !== {DW'(0), 1'b0, SW'(SI), 2'd0}) begin
         errors++;
         $display("FAIL reset_mid got duty=%0d load=%0b speed=%0d phase=%0d exp 0/0/%0d/0", duty, load, speed, phase, SI);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk); n++;
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_reset_mid t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end while (!load && n < 40);
      checks++;
      if (n != FRAME) begin errors++; $display("FAIL reset_mid_first_load got %0d exp %0d", n, FRAME); end
   endtask

   task automatic test_speed_change;
      int n = 0, k = 0;
      while (!(m_pace == 8 && (m_cyc % FRAME) == 0) && n < 400) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 400) begin errors++; $display("FAIL pace8_sync got timeout exp pace 8"); end
      // 11 up-edges; speed passes 11 (threshold 4 < pace 8) before the next tick and reaches 15 by the one after
      for (int c = 0; c < 5 * FRAME; c++) begin
         key_up = (c < 22) && (c % 2 == 0);
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin errors++; $display("FAIL model_spdchg t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
         if (load) begin
            k++;
            checks++;
            if (int'(duty) != k || phase != 2'd0) begin errors++; $display("FAIL spdchg_load%0d got duty=%0d phase=%0d exp duty=%0d phase=0", k, duty, phase, k); end
         end
      end
      checks++;
      if (k != 5) begin errors++; $display("FAIL spdchg_loads got %0d exp 5", k); end
   endtask

   initial begin
      test_reset;
      test_frame_timing;
      test_speed_sat;
      test_simultaneous;
      test_envelope;
      test_reset_mid;
      test_speed_change;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
